// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: row-scanned LED matrix driver with a double-buffered frame input.
// Frames swap only at frame boundaries, and a blanking gap precedes every row.
module led_matrix_scanner #(
  parameter int ROWS = 5,
  parameter int COLS = 5,
  parameter int DWELL_CYC = 1000,
  parameter int BLANK_CYC = 4
) (
  input  logic                 iClk,
  input  logic                 iRst_n,
  input  logic                 iEnable,
  input  logic [ROWS*COLS-1:0] iFrame,
  input  logic                 iFrame_valid,
  output logic                 oFrame_ready,
  output logic [ROWS-1:0]      oRow,
  output logic [COLS-1:0]      oCol,
  output logic                 oFrame_done
);
  localparam int MAXC = DWELL_CYC > BLANK_CYC ? DWELL_CYC : BLANK_CYC;
  localparam int CW = $clog2(MAXC + 1);
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [RW-1:0] row, nextRow;
  logic [ROWS*COLS-1:0] active, pending, shownFrame;
  logic dwellEnd, lastRow, swap;
  assign dwellEnd = state == DRIVE && cnt == CW'(DWELL_CYC - 1);
  assign lastRow = row == RW'(ROWS - 1);
  // Swap needs a full pending buffer, i.e. ready low as registered before this edge.
  assign swap = iEnable && (state == IDLE || (dwellEnd && lastRow)) && !oFrame_ready;
  assign nextRow = (state == IDLE || lastRow) ? '0 : row + RW'(1);
  assign shownFrame = swap ? pending : active;
  always_ff @(posedge iClk or negedge iRst_n)
    if (!iRst_n) begin
      state <= IDLE;
      cnt <= '0;
      row <= '0;
      active <= '0;
      pending <= '0;
      oFrame_ready <= 1'b1;
      oRow <= '0;
      oCol <= '1;
      oFrame_done <= 1'b0;
    end else begin
      oFrame_done <= 1'b0;
      if (iFrame_valid && oFrame_ready) begin
        pending <= iFrame;
        oFrame_ready <= 1'b0;
      end
      if (swap) begin
        active <= pending;
        oFrame_ready <= 1'b1;
      end
      if (!iEnable) begin
        state <= IDLE;
        cnt <= '0;
        row <= '0;
        oRow <= '0;
        oCol <= '1;
      end else if (state == BLANK) begin
        if (cnt == CW'(BLANK_CYC - 1)) begin
          cnt <= '0;
          state <= DRIVE;
          oRow <= ROWS'(1) << row;
          oCol <= ~active[row*COLS +: COLS];
        end else
          cnt <= cnt + CW'(1);
      end else if (state == DRIVE && !dwellEnd)
        cnt <= cnt + CW'(1);
      else begin
        // Leaving IDLE or finishing a dwell: move on to the next row's phase.
        oFrame_done <= state == DRIVE && lastRow;
        row <= nextRow;
        cnt <= '0;
        state <= BLANK_CYC == 0 ? DRIVE : BLANK;
        oRow <= BLANK_CYC == 0 ? ROWS'(1) << nextRow : '0;
        oCol <= BLANK_CYC == 0 ? ~shownFrame[nextRow*COLS +: COLS] : '1;
      end
    end
endmodule

// File: tb/tb_led_matrix_scanner.sv
// tb_led_matrix_scanner: scoreboard bench; expected per-cycle {oRow,oCol,oFrame_done}
// words are queued from the loaded bitmaps and compared as the scan produces them.
module tb_led_matrix_scanner;
  localparam int R = 5, C = 5, DW = 4, BL = 2;
  localparam logic [24:0] FA = 25'h0AA_AAAA, FB = 25'h123_4567, FC = 25'h155_5555, FD = 25'h00F_0F0F;
  logic iClk = 1'b0, iRst_n = 1'b0, iEnable = 1'b0, iFrame_valid = 1'b0;
  logic [24:0] iFrame = '0;
  logic oFrame_ready, oFrame_done;
  logic [4:0] oRow, oCol;
  logic [10:0] sb[$];
  logic [10:0] e;
  logic expReady;
  int tests = 0, fails = 0;

  led_matrix_scanner #(.ROWS(R), .COLS(C), .DWELL_CYC(DW), .BLANK_CYC(BL)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iEnable(iEnable), .iFrame(iFrame),
    .iFrame_valid(iFrame_valid), .oFrame_ready(oFrame_ready), .oRow(oRow),
    .oCol(oCol), .oFrame_done(oFrame_done)
  );

  always #5 iClk = ~iClk;

  task automatic pushFrame(input logic [24:0] f, input logic d);
    logic [4:0] oh;
    for (int r = 0; r < R; r++) begin
      oh = 5'd1 << r;
      for (int b = 0; b < BL; b++) sb.push_back({5'd0, 5'h1F, (r == 0 && b == 0) ? d : 1'b0});
      for (int c = 0; c < DW; c++) sb.push_back({oh, ~f[r*C +: C], 1'b0});
    end
  endtask

  task automatic pushOff(input int n);
    for (int i = 0; i < n; i++) sb.push_back({5'd0, 5'h1F, 1'b0});
  endtask

  task automatic loadFrame(input logic [24:0] f);
    iFrame = f;
    iFrame_valid = 1'b1;
    @(negedge iClk);
    iFrame_valid = 1'b0;
  endtask

  task automatic test_reset;
    iRst_n = 1'b0;
    repeat (3) @(negedge iClk);
    tests++;
    if ({oRow, oCol, oFrame_done, oFrame_ready} !== {5'd0, 5'h1F, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL reset got row=%b col=%b done=%b ready=%b want 00000 11111 0 1", oRow, oCol, oFrame_done, oFrame_ready);
    end
    iRst_n = 1'b1;
  endtask

  task automatic test_single_pixel;
    loadFrame(25'h000_0001);
    tests++;
    if (oFrame_ready !== 1'b0) begin
      fails++;
      $display("FAIL single_pixel_ready got %b want 0", oFrame_ready);
    end
    iEnable = 1'b1;
    pushFrame(25'h000_0001, 1'b0);
    pushFrame(25'h000_0001, 1'b1);
    pushOff(1);
    for (int k = 0; sb.size() > 0; k++) begin
      @(negedge iClk);
      e = sb.pop_front();
      tests++;
      if ({oRow, oCol, oFrame_done} !== e) begin
        fails++;
        $display("FAIL single_pixel k=%0d got row=%b col=%b done=%b want row=%b col=%b done=%b", k, oRow, oCol, oFrame_done, e[10:6], e[5:1], e[0]);
      end
      if (k == 59) iEnable = 1'b0;
    end
  endtask

  task automatic test_full_frame;
    loadFrame(25'h1FF_FFFF);
    iEnable = 1'b1;
    pushFrame(25'h1FF_FFFF, 1'b0);
    pushOff(1);
    for (int k = 0; sb.size() > 0; k++) begin
      @(negedge iClk);
      e = sb.pop_front();
      tests++;
      if ({oRow, oCol, oFrame_done} !== e) begin
        fails++;
        $display("FAIL full_frame k=%0d got row=%b col=%b done=%b want row=%b col=%b done=%b", k, oRow, oCol, oFrame_done, e[10:6], e[5:1], e[0]);
      end
      if (k == 29) iEnable = 1'b0;
    end
  endtask

  task automatic test_backpressure;
    iEnable = 1'b1;
    pushFrame(25'h1FF_FFFF, 1'b0);
    pushFrame(FA, 1'b1);
    pushFrame(FB, 1'b1);
    pushOff(1);
    for (int k = 0; sb.size() > 0; k++) begin
      @(negedge iClk);
      e = sb.pop_front();
      expReady = k == 0 || k == 30 || k >= 60;
      tests += 2;
      if ({oRow, oCol, oFrame_done} !== e) begin
        fails++;
        $display("FAIL backpressure k=%0d got row=%b col=%b done=%b want row=%b col=%b done=%b", k, oRow, oCol, oFrame_done, e[10:6], e[5:1], e[0]);
      end
      if (oFrame_ready !== expReady) begin
        fails++;
        $display("FAIL backpressure_ready k=%0d got %b want %b", k, oFrame_ready, expReady);
      end
      if (k == 0) begin
        iFrame_valid = 1'b1;
        iFrame = FA;
      end
      if (k == 1) iFrame = FB;
      if (k == 31) iFrame_valid = 1'b0;
      if (k == 89) iEnable = 1'b0;
    end
  endtask

  task automatic test_boundary_accept;
    iEnable = 1'b1;
    pushFrame(FB, 1'b0);
    pushFrame(FB, 1'b1);
    pushFrame(FC, 1'b1);
    pushOff(1);
    for (int k = 0; sb.size() > 0; k++) begin
      @(negedge iClk);
      e = sb.pop_front();
      expReady = k < 30 || k >= 60;
      tests += 2;
      if ({oRow, oCol, oFrame_done} !== e) begin
        fails++;
        $display("FAIL boundary_accept k=%0d got row=%b col=%b done=%b want row=%b col=%b done=%b", k, oRow, oCol, oFrame_done, e[10:6], e[5:1], e[0]);
      end
      if (oFrame_ready !== expReady) begin
        fails++;
        $display("FAIL boundary_ready k=%0d got %b want %b", k, oFrame_ready, expReady);
      end
      if (k == 29) begin
        iFrame_valid = 1'b1;
        iFrame = FC;
      end
      if (k == 30) iFrame_valid = 1'b0;
      if (k == 89) iEnable = 1'b0;
    end
  endtask

  task automatic test_disable_mid_row;
    iEnable = 1'b1;
    pushFrame(FC, 1'b0);
    for (int k = 0; sb.size() > 0; k++) begin
      @(negedge iClk);
      e = sb.pop_front();
      tests++;
      if ({oRow, oCol, oFrame_done} !== e) begin
        fails++;
        $display("FAIL disable_mid_row k=%0d got row=%b col=%b done=%b want row=%b col=%b done=%b", k, oRow, oCol, oFrame_done, e[10:6], e[5:1], e[0]);
      end
      if (k == 15) begin
        iEnable = 1'b0;
        sb.delete();
        pushOff(3);
      end
      if (k == 18) begin
        iEnable = 1'b1;
        pushFrame(FC, 1'b0);
        pushOff(1);
      end
      if (k == 48) iEnable = 1'b0;
    end
  endtask

  task automatic test_reset_mid_drive;
    iEnable = 1'b1;
    pushFrame(FC, 1'b0);
    for (int k = 0; sb.size() > 0; k++) begin
      @(negedge iClk);
      e = sb.pop_front();
      tests++;
      if ({oRow, oCol, oFrame_done} !== e) begin
        fails++;
        $display("FAIL pre_reset k=%0d got row=%b col=%b done=%b want row=%b col=%b done=%b", k, oRow, oCol, oFrame_done, e[10:6], e[5:1], e[0]);
      end
      if (k == 0) begin
        iFrame_valid = 1'b1;
        iFrame = FD;
      end
      if (k == 1) begin
        iFrame_valid = 1'b0;
        tests++;
        if (oFrame_ready !== 1'b0) begin
          fails++;
          $display("FAIL pre_reset_ready got %b want 0", oFrame_ready);
        end
      end
      if (k == 3) begin
        sb.delete();
        iRst_n = 1'b0;
        iEnable = 1'b0;
        #1;
        tests++;
        if ({oRow, oCol, oFrame_done, oFrame_ready} !== {5'd0, 5'h1F, 1'b0, 1'b1}) begin
          fails++;
          $display("FAIL async_reset got row=%b col=%b done=%b ready=%b want 00000 11111 0 1", oRow, oCol, oFrame_done, oFrame_ready);
        end
      end
    end
    @(negedge iClk);
    iRst_n = 1'b1;
    iEnable = 1'b1;
    pushFrame(25'h0, 1'b0);
    pushOff(1);
    for (int k = 0; sb.size() > 0; k++) begin
      @(negedge iClk);
      e = sb.pop_front();
      tests++;
      if ({oRow, oCol, oFrame_done} !== e) begin
        fails++;
        $display("FAIL post_reset k=%0d got row=%b col=%b done=%b want row=%b col=%b done=%b", k, oRow, oCol, oFrame_done, e[10:6], e[5:1], e[0]);
      end
      if (k == 29) iEnable = 1'b0;
    end
  endtask

  initial begin
    test_reset;
    test_single_pixel;
    test_full_frame;
    test_backpressure;
    test_boundary_accept;
    test_disable_mid_row;
    test_reset_mid_drive;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
